elevator_dest_scheduler: RTL
============================

ELEVATOR_DEST_SCHEDULER -- requirements
Module: elevator_dest_scheduler

Interface
REQ-001 Parameter N_FLOORS, default 8, number of served floors (2..64).
REQ-002 Parameter DWELL_CYCLES, default 4, door-open dwell length in clock cycles (>=1).
REQ-003 Derived FLOOR_W = max(1, clog2(N_FLOORS)), width of every floor index.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  floor call present this cycle.
REQ-007 req_floor  input  FLOOR_W  floor being called; sampled only when req_valid=1.
REQ-008 current_floor  input  FLOOR_W  car position reported by the motion controller.
REQ-009 at_floor  input  1  one-cycle pulse: car has just aligned with current_floor.
REQ-010 pending  output  N_FLOORS  registered set of outstanding calls, bit i = floor i.
REQ-011 queue_empty  output  1  registered, 1 when pending is all zero.
REQ-012 dir_up  output  1  registered travel direction: 1 = up, 0 = down.
REQ-013 move_en  output  1  registered, 1 commands the car to travel in dir_up.
REQ-014 door_open  output  1  registered, 1 while the door dwells.

Function
REQ-015 FSM states SHALL be IDLE, MOVING and DWELL; move_en=1 only in MOVING, door_open=1 only in DWELL.
REQ-016 A call with req_valid=1 and req_floor<N_FLOORS SHALL set pending[req_floor] on the next edge; a call with req_floor>=N_FLOORS SHALL be ignored.
REQ-017 ahead_up SHALL be any pending bit above current_floor; ahead_dn SHALL be any pending bit below current_floor; both SHALL be computed from the registered pending.
REQ-018 IDLE, pending[current_floor]=1: the next state SHALL be DWELL, that bit SHALL be cleared and the dwell counter SHALL be loaded.
REQ-019 IDLE, otherwise with pending nonzero: dir_up SHALL become 1 if only ahead_up, 0 if only ahead_dn, and keep its value if both; the next state SHALL be MOVING.
REQ-020 IDLE with pending zero SHALL hold IDLE and keep dir_up unchanged.
REQ-021 MOVING, at_floor=1 and pending[current_floor]=1: the next state SHALL be DWELL, that bit SHALL be cleared and move_en SHALL drop on the same edge.
REQ-022 MOVING, at_floor=1 with no hit and no pending bit ahead in dir_up: the next state SHALL be IDLE, which then applies REQ-019 (reversal).
REQ-023 MOVING without at_floor SHALL hold state; calls arriving SHALL only update pending.
REQ-024 DWELL SHALL last exactly DWELL_CYCLES cycles of door_open=1 and then enter IDLE.
REQ-025 A call for current_floor accepted during DWELL SHALL NOT set pending; it SHALL reload the dwell counter (door re-open).
REQ-026 When a set and a clear of the same pending bit coincide on one edge, the clear SHALL win.
REQ-027 queue_empty SHALL equal the NOR of pending after that edge's update, with no extra cycle of lag.
REQ-028 At floor N_FLOORS-1 ahead_up SHALL be 0, and at floor 0 ahead_dn SHALL be 0; there is no index wrap.

Reset
REQ-029 rst=1 SHALL force on the next edge: state IDLE, pending 0, queue_empty 1, dir_up 1, move_en 0, door_open 0, dwell counter 0.
REQ-030 rst SHALL override every other input on that edge, including mid-MOVING and mid-DWELL; calls presented during reset SHALL be dropped.

Structure
REQ-031 Package elevator_pkg SHALL hold the state enum and a FLOOR_W helper function; all modules of the car subsystem SHALL share it.
REQ-032 The ahead/behind detection of REQ-017 SHALL be one combinational sub-module, elevator_dir_select, parametrised by N_FLOORS.
REQ-033 The dwell counter SHALL be clog2(DWELL_CYCLES+1) bits wide and SHALL saturate at 0.

Verification (N_FLOORS=8, DWELL_CYCLES=4)
REQ-034 Reset, then call floor 5 with car at 2 -> pending=0x20, dir_up=1, move_en=1; at_floor at 5 -> door_open for exactly 4 cycles, pending=0, queue_empty=1.
REQ-035 Car at 4 moving up to 6, call floor 1 -> stop at 6, then IDLE, then dir_up=0, move_en=1 (reversal).
REQ-036 Call floor 3 during DWELL at 3 -> pending unchanged and door_open extended to 4 cycles from the call.
REQ-037 req_floor=9 with req_valid=1 -> pending stays 0 and state stays IDLE.
REQ-038 Calls at 7 and 0 from floor 7 while idle -> immediate DWELL at 7; at_floor pulses with no hit at 6..1 -> car continues down to 0.
REQ-039 rst asserted in MOVING with pending=0x81 -> next cycle all outputs at reset values and pending=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car subsystem.
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVING,
      ST_DWELL
   } car_state_e;

   // Width of a floor index; a two-floor building still needs one bit.
   function automatic int floor_w(input int n_floors);
      return (n_floors > 2) ? $clog2(n_floors) : 1;
   endfunction

endpackage

// File: rtl/elevator_dir_select.sv
// Detects outstanding calls above and below the car's current floor.
module elevator_dir_select
   import elevator_pkg::*;
#(
   parameter  int N_FLOORS = 8,
   localparam int FLOOR_W  = floor_w(N_FLOORS)
) (
   input  logic [N_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]  current_floor,
   output logic                ahead_up,
   output logic                ahead_dn
);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ahead_up = 1'b0;
      ahead_dn = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) > current_floor)) ahead_up = 1'b1;
         if (pending[i] && (FLOOR_W'(i) < current_floor)) ahead_dn = 1'b1;
      end
   end

endmodule

// File: rtl/elevator_dest_scheduler.sv
// Destination scheduler for one elevator car: latches floor calls, picks a
// travel direction, and sequences IDLE / MOVING / DWELL.
module elevator_dest_scheduler
   import elevator_pkg::*;
#(
   parameter  int N_FLOORS     = 8,
   parameter  int DWELL_CYCLES = 4,
   localparam int FLOOR_W      = floor_w(N_FLOORS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [FLOOR_W-1:0]  req_floor,
   input  logic [FLOOR_W-1:0]  current_floor,
   input  logic                at_floor,
   output logic [N_FLOORS-1:0] pending,
   output logic                queue_empty,
   output logic                dir_up,
   output logic                move_en,
   output logic                door_open
);

   localparam int               CNT_W      = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);

   car_state_e          state, state_n;
   logic [N_FLOORS-1:0] pending_n, set_mask, clr_mask, req_mask, cur_mask;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                dir_n, hit, ahead_up, ahead_dn;

   elevator_dir_select #(.N_FLOORS(N_FLOORS)) u_dir_select (
      .pending       (pending),
      .current_floor (current_floor),
      .ahead_up      (ahead_up),
      .ahead_dn      (ahead_dn)
   );

   // One-hot decodes; out-of-range floor codes simply match no bit.
   always_comb begin
      req_mask = '0;
      cur_mask = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         req_mask[i] = req_valid && (req_floor == FLOOR_W'(i));
         cur_mask[i] = (current_floor == FLOOR_W'(i));
      end
   end

   assign hit = |(pending & cur_mask);

   always_comb begin
      state_n  = state;
      dir_n    = dir_up;
      cnt_n    = cnt;
      set_mask = req_mask;
      clr_mask = '0;
      unique case (state)
         ST_IDLE: begin
            if (hit) begin
               state_n  = ST_DWELL;
               clr_mask = cur_mask;
               cnt_n    = DWELL_LOAD;
            end else if (|pending) begin
               if (ahead_up && !ahead_dn)      dir_n = 1'b1;
               else if (ahead_dn && !ahead_up) dir_n = 1'b0;
               state_n = ST_MOVING;
            end
         end
         ST_MOVING: begin
            if (at_floor) begin
               if (hit) begin
                  state_n  = ST_DWELL;
                  clr_mask = cur_mask;
                  cnt_n    = DWELL_LOAD;
               end else if (!(dir_up ? ahead_up : ahead_dn)) begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_DWELL: begin
            // A call for the open floor re-opens the door instead of queueing.
            clr_mask = cur_mask;
            if (|(req_mask & cur_mask)) begin
               cnt_n = DWELL_LOAD;
            end else if (cnt == '0 || cnt == CNT_W'(1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // Clear wins over a coincident set of the same floor.
      pending_n = (pending | set_mask) & ~clr_mask;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pending     <= '0;
         queue_empty <= 1'b1;
         dir_up      <= 1'b1;
         move_en     <= 1'b0;
         door_open   <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         pending     <= pending_n;
         queue_empty <= ~|pending_n;
         dir_up      <= dir_n;
         move_en     <= (state_n == ST_MOVING);
         door_open   <= (state_n == ST_DWELL);
         cnt         <= cnt_n;
      end
   end

endmodule
